// File: rtl/ed_avg_detector.sv
// Per-bin power averager with threshold detection over 2^avg_log2-frame windows.
// Optional per-bin detection hysteresis is enabled by defining ED_HYST_EN.
module ed_avg_detector #(
  parameter int          FFT_LOG2     = 8,
  parameter int          DW           = 32,
  parameter int          AVG_LOG2_MAX = 4,
  parameter logic [7:0]  SR_BASE      = 8'd3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                set_stb,
  input  logic [7:0]          set_addr,
  input  logic [31:0]         set_data,
  input  logic                dv_in,
  input  logic                sof_in,
  input  logic [DW-1:0]       data_in,
  output logic                strobe_out,
  output logic [DW-1:0]       data_out,
  output logic [FFT_LOG2-1:0] bin_out,
  output logic                det_out,
  output logic                sof_out
);

  localparam int NB = 1 << FFT_LOG2;
  localparam int AW = DW + AVG_LOG2_MAX;
  localparam int FW = (AVG_LOG2_MAX > 0) ? AVG_LOG2_MAX : 1;
  localparam logic [7:0] A_THR_HI = SR_BASE;
  localparam logic [7:0] A_CTRL   = SR_BASE + 8'd1;
`ifdef ED_HYST_EN
  localparam logic [7:0] A_THR_LO = SR_BASE + 8'd2;
`endif
  localparam logic [2:0] LOG2_CAP = 3'((AVG_LOG2_MAX > 7) ? 7 : AVG_LOG2_MAX);
  localparam logic [FFT_LOG2-1:0] BIN_LAST = '1;

  // settings registers
  logic [DW-1:0] thr_hi;
  logic [2:0]    avg_log2;
  logic [2:0]    ctrl_log2;
  logic          wr_ctrl;
`ifdef ED_HYST_EN
  logic [DW-1:0] thr_lo;
`endif

  logic unused_set;
  assign unused_set = ^set_data;

  always_comb begin
    wr_ctrl   = set_stb && (set_addr == A_CTRL);
    ctrl_log2 = (set_data[2:0] > LOG2_CAP) ? LOG2_CAP : set_data[2:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      thr_hi   <= '1;
      avg_log2 <= '0;
`ifdef ED_HYST_EN
      thr_lo   <= '1;
`endif
    end else if (set_stb) begin
      if (set_addr == A_THR_HI) thr_hi <= set_data[DW-1:0];
      if (set_addr == A_CTRL)   avg_log2 <= ctrl_log2;
`ifdef ED_HYST_EN
      if (set_addr == A_THR_LO) thr_lo <= set_data[DW-1:0];
`endif
    end
  end

  // bin / frame counters
  logic [FFT_LOG2-1:0] bin_cnt, bin_cur;
  logic [FW-1:0]       frm_cnt, frm_cur, frm_nxt, frm_mask;
  logic                forced_wrap;

  function automatic logic [FW-1:0] frm_inc(input logic [FW-1:0] f, input logic [FW-1:0] m);
    return (f == m) ? '0 : f + FW'(1);
  endfunction

  // An sof_in arriving mid-frame closes the current frame first, so the
  // resync sample belongs to the following frame.
  always_comb begin
    frm_mask    = FW'((32'd1 << avg_log2) - 32'd1);
    forced_wrap = sof_in && (bin_cnt != '0);
    bin_cur     = sof_in ? '0 : bin_cnt;
    frm_cur     = forced_wrap ? frm_inc(frm_cnt, frm_mask) : frm_cnt;
    frm_nxt     = (bin_cur == BIN_LAST) ? frm_inc(frm_cur, frm_mask) : frm_cur;
  end

  always_ff @(posedge clock) begin
    if (reset || wr_ctrl) begin
      bin_cnt <= '0;
      frm_cnt <= '0;
    end else if (dv_in) begin
      bin_cnt <= bin_cur + FFT_LOG2'(1);
      frm_cnt <= frm_nxt;
    end
  end

  // stage 1: sample, bin and window flags registered alongside the RAM read
  logic                s1_vld, s1_first, s1_last;
  logic [FFT_LOG2-1:0] s1_bin;
  logic [DW-1:0]       s1_data;
  logic [2:0]          s1_log2;

  always_ff @(posedge clock) begin
    if (reset) s1_vld <= 1'b0;
    else       s1_vld <= dv_in;
    if (dv_in) begin
      s1_bin   <= bin_cur;
      s1_data  <= data_in;
      s1_first <= (frm_cur == '0);
      s1_last  <= (frm_cur == frm_mask);
      s1_log2  <= avg_log2;
    end
  end

  // accumulator RAM
  logic [AW-1:0] acc_ram [NB];
  logic [AW-1:0] acc_q, acc_sum;
  logic [DW-1:0] avg;

  always_comb begin
    acc_sum = (s1_first ? '0 : acc_q) + AW'(s1_data);
    avg     = DW'(acc_sum >> s1_log2);
  end

  always_ff @(posedge clock) begin
    if (s1_vld) acc_ram[s1_bin] <= acc_sum;
    acc_q <= acc_ram[bin_cur];
  end

  // detection
  logic det_nxt;
`ifdef ED_HYST_EN
  logic [NB-1:0] hyst_q;

  always_comb begin
    if (avg > thr_hi)      det_nxt = 1'b1;
    else if (avg < thr_lo) det_nxt = 1'b0;
    else                   det_nxt = hyst_q[s1_bin];
  end

  always_ff @(posedge clock) begin
    if (reset || wr_ctrl)     hyst_q <= '0;
    else if (s1_vld && s1_last) hyst_q[s1_bin] <= det_nxt;
  end
`else
  always_comb det_nxt = (avg > thr_hi);
`endif

  // stage 2 outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      strobe_out <= 1'b0;
      data_out   <= '0;
      bin_out    <= '0;
      det_out    <= 1'b0;
      sof_out    <= 1'b0;
    end else begin
      strobe_out <= s1_vld && s1_last;
      sof_out    <= s1_vld && s1_last && (s1_bin == '0);
      if (s1_vld && s1_last) begin
        data_out <= avg;
        bin_out  <= s1_bin;
        det_out  <= det_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ed_avg_detector.sv
// Scoreboard bench for ed_avg_detector: directed frames push expected outputs,
// a negedge monitor pops and compares whenever strobe_out is seen.
module tb_ed_avg_detector;

  logic        clock = 1'b0;
  logic        reset;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic        dv_in, sof_in;
  logic [31:0] data_in;
  logic        strobe_out, det_out, sof_out;
  logic [31:0] data_out;
  logic [7:0]  bin_out;

  ed_avg_detector #(
    .FFT_LOG2(8), .DW(32), .AVG_LOG2_MAX(4), .SR_BASE(8'd3)
  ) dut (
    .clock(clock), .reset(reset),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .dv_in(dv_in), .sof_in(sof_in), .data_in(data_in),
    .strobe_out(strobe_out), .data_out(data_out), .bin_out(bin_out),
    .det_out(det_out), .sof_out(sof_out)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          due;
    logic [7:0]  bin;
    logic [31:0] data;
    logic        det;
    logic        sof;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  logic [31:0] avg_tbl  [4] = '{32'd10, 32'd20, 32'd30, 32'd41};
  logic [31:0] hyst_tbl [4] = '{32'd120, 32'd80, 32'd40, 32'd80};
`ifdef ED_HYST_EN
  logic        hdet_tbl [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
  logic        hdet_tbl [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
`endif

  always @(negedge clock) begin
    if (strobe_out === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe cyc=%0d bin=%0d data=%0h", cyc, bin_out, data_out);
      end else begin
        mon_e = q.pop_front();
        if (cyc != mon_e.due || bin_out !== mon_e.bin || data_out !== mon_e.data ||
            det_out !== mon_e.det || sof_out !== mon_e.sof) begin
          bad++;
          $display("FAIL output cyc got=%0d exp=%0d bin got=%0d exp=%0d data got=%0h exp=%0h det got=%0b exp=%0b sof got=%0b exp=%0b",
                   cyc, mon_e.due, bin_out, mon_e.bin, data_out, mon_e.data,
                   det_out, mon_e.det, sof_out, mon_e.sof);
        end
      end
    end else begin
      if (sof_out === 1'b1) begin
        total++; bad++;
        $display("FAIL sof_without_strobe cyc=%0d got=1 exp=0", cyc);
      end
      if (q.size() > 0 && cyc > q[0].due) begin
        total++; bad++;
        $display("FAIL missing_strobe bin=%0d due=%0d now=%0d", q[0].bin, q[0].due, cyc);
        void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sr_write(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick();
    set_stb = 1'b0;
  endtask

  task automatic sample(input logic sof, input logic [31:0] d, input bit exp_en,
                        input logic [7:0] eb, input logic [31:0] ed, input logic edet);
    exp_t e;
    dv_in = 1'b1; sof_in = sof; data_in = d;
    if (exp_en) begin
      e.due = cyc + 2; e.bin = eb; e.data = ed; e.det = edet; e.sof = (eb == 8'd0);
      q.push_back(e);
    end
    tick();
    dv_in = 1'b0; sof_in = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_strobe", 64'(strobe_out), 64'd0);
    chk("rst_data",   64'(data_out),   64'd0);
    chk("rst_bin",    64'(bin_out),    64'd0);
    chk("rst_det",    64'(det_out),    64'd0);
    chk("rst_sof",    64'(sof_out),    64'd0);
  endtask

  initial begin
    logic [31:0] d, ev;
    reset = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
    dv_in = 1'b0; sof_in = 1'b0; data_in = '0;
    idle(3);
    chk_reset_outputs();
    reset = 1'b0;
    tick();

    // passthrough with avg_log2=0, data = bin index, thr_hi=100
    sr_write(8'd3, 32'd100);
    sr_write(8'd4, 32'd0);
    for (int b = 0; b < 256; b++)
      sample(b == 0, 32'(b), 1, 8'(b), 32'(b), b > 100);
    idle(4);

    // 4-frame averaging; bin 5 = 10,20,30,41 -> 25; others 4b+f -> 4b+1; bin 255 near full scale
    sr_write(8'd4, 32'd2);
    for (int f = 0; f < 4; f++)
      for (int b = 0; b < 256; b++) begin
        if (b == 5)        begin d = avg_tbl[f];               ev = 32'd25;         end
        else if (b == 255) begin d = 32'hFFFF_FFF0 - 32'(f);   ev = 32'hFFFF_FFEE;  end
        else               begin d = 32'(4 * b + f);           ev = 32'(4 * b + 1); end
        sample(b == 0, d, f == 3, 8'(b), ev, ev > 32'd100);
      end
    idle(4);

    // resync: sof at counter 37 starts a new window at bin 0
    sr_write(8'd4, 32'd1);
    for (int b = 0; b < 256; b++) sample(b == 0, 32'(2 * b), 0, 8'd0, 32'd0, 1'b0);
    for (int b = 0; b < 37; b++)  sample(b == 0, 32'(2 * b + 2), 1, 8'(b), 32'(2 * b + 1), 1'b0);
    sample(1'b1, 32'd10, 0, 8'd0, 32'd0, 1'b0);
    for (int b = 1; b < 256; b++) sample(1'b0, 32'(2 * b), 0, 8'd0, 32'd0, 1'b0);
    for (int b = 0; b < 256; b++) begin
      ev = (b == 0) ? 32'd7 : 32'(2 * b + 2);
      sample(b == 0, 32'(2 * b + 4), 1, 8'(b), ev, ev > 32'd100);
    end
    idle(4);

    // restart mid-window discards the partial accumulation
    sr_write(8'd4, 32'd1);
    for (int b = 0; b < 100; b++) sample(1'b0, 32'd9999, 0, 8'd0, 32'd0, 1'b0);
    sr_write(8'd4, 32'd1);
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < 256; b++)
        sample(1'b0, 32'(3 * b + 2 * f), f == 1, 8'(b), 32'(3 * b + 1), (3 * b + 1) > 100);
    idle(4);

    // hysteresis sequence on bin 3; write below SR_BASE must be ignored
    sr_write(8'd5, 32'd50);
    sr_write(8'd2, 32'd0);
    sr_write(8'd4, 32'd0);
    for (int f = 0; f < 4; f++)
      for (int b = 0; b < 256; b++) begin
        d = (b == 3) ? hyst_tbl[f] : 32'd0;
        sample(b == 0, d, 1, 8'(b), d, (b == 3) ? hdet_tbl[f] : 1'b0);
      end
    idle(4);

    // gapped input, then reset mid-frame with a sample still in flight
    for (int b = 0; b < 256; b++) begin
      sample(b == 0, 32'(b + 7), 1, 8'(b), 32'(b + 7), (b + 7) > 100);
      idle($urandom_range(0, 2));
    end
    idle(4);
    for (int b = 0; b < 128; b++) begin
      sample(b == 0, 32'(b + 7), 1, 8'(b), 32'(b + 7), (b + 7) > 100);
      idle($urandom_range(0, 2));
    end
    sample(1'b0, 32'd135, 0, 8'd0, 32'd0, 1'b0);
    reset = 1'b1;
    idle(2);
    chk_reset_outputs();
    reset = 1'b0;
    // after reset: thr_hi all ones, avg_log2 0, no sof needed for bin 0
    for (int b = 0; b < 256; b++) begin
      sample(1'b0, 32'(b + 7), 1, 8'(b), 32'(b + 7), 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(6);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
